// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared state encoding and default constants for the pulse meter
// and related input-capture blocks.
`default_nettype none

package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam int unsigned CLOCK_FREQUENCY = 50000000;
  localparam int          DEF_CNT_W       = 32;
  localparam int          DEF_TIMEOUT     = 50000000;

endpackage

`default_nettype wire

// File: rtl/pulse_meter_sync_edge_det.sv
// sync_edge_det: input synchroniser, optional deglitch filter and rise/fall detector.
// Optional filter enabled by defining PULSE_METER_DEGLITCH_EN.
`default_nettype none

module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || DEGLITCH < 1) begin : g_param_check
    $error("sync_edge_det: SYNC_STAGES must be >= 2 and DEGLITCH >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   filt;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef PULSE_METER_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH) + 1;
  logic [DG_W-1:0] dg_cnt;

  // A differing sample must persist DEGLITCH cycles; any return to the held level restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b0;
      dg_cnt <= '0;
    end else if (sync_s == filt) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
      filt   <= sync_s;
      dg_cnt <= '0;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end
`else
  assign filt = sync_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= filt;
    end
  end

  assign level = filt;
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;

endmodule

`default_nettype wire

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, low time and period of an asynchronous square wave.
// Optional input deglitch filter enabled by defining PULSE_METER_DEGLITCH_EN.
`default_nettype none

module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stalled,
  output logic             level
);

  localparam int               IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rise;
  logic fall;
  logic any_edge;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEGLITCH    (DEGLITCH)
  ) u_sync_edge_det (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hi_acc, lo_acc, hi_nxt, lo_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic             timeout_hit;
  logic             capture;
  logic [CNT_W:0]   sum_full;
  logic [CNT_W-1:0] period_sat;

  assign any_edge    = rise | fall;
  // idle_cnt holds cycles since the last edge, so this fires TIMEOUT cycles after it.
  assign timeout_hit = !any_edge && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign sum_full    = {1'b0, hi_acc} + {1'b0, lo_acc};
  assign period_sat  = sum_full[CNT_W] ? CNT_MAX : sum_full[CNT_W-1:0];

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_acc;
    lo_nxt    = lo_acc;
    capture   = 1'b0;
    if (timeout_hit) begin
      state_nxt = IDLE;
      hi_nxt    = '0;
      lo_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          hi_nxt = '0;
          lo_nxt = '0;
          if (rise) begin
            hi_nxt    = CNT_W'(1);
            state_nxt = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            lo_nxt    = CNT_W'(1);
            state_nxt = MEAS_LOW;
          end else if (hi_acc != CNT_MAX) begin
            hi_nxt = hi_acc + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            capture   = 1'b1;
            hi_nxt    = CNT_W'(1);
            state_nxt = MEAS_HIGH;
          end else if (lo_acc != CNT_MAX) begin
            lo_nxt = lo_acc + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          hi_nxt    = '0;
          lo_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hi_acc <= '0;
      lo_acc <= '0;
    end else begin
      state  <= state_nxt;
      hi_acc <= hi_nxt;
      lo_acc <= lo_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (any_edge) begin
      idle_cnt <= IDLE_W'(1);
    end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        high_cnt <= hi_acc;
        low_cnt  <= lo_acc;
        period   <= period_sat;
      end
      if (timeout_hit) begin
        stalled <= 1'b1;
      end else if (state == IDLE && rise) begin
        stalled <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
